// File: rtl/rv32_bus_pkg.sv
// Shared types for the rv32 memory-bus arbiter: FSM state and the latched bus request.
// Request fields are sized for the widest supported bus; narrower instances zero-extend.
package rv32_bus_pkg;

    localparam int RV32_BUS_MAX_ADDR = 64;
    localparam int RV32_BUS_MAX_DATA = 64;
    localparam int RV32_BUS_MAX_MASK = RV32_BUS_MAX_DATA / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_t;

    typedef struct packed {
        logic [RV32_BUS_MAX_ADDR-1:0] address;
        logic [RV32_BUS_MAX_MASK-1:0] write_mask;
        logic [RV32_BUS_MAX_DATA-1:0] write_value;
    } rv32_bus_req_t;

endpackage

// File: rtl/rv32_rr_arbiter.sv
// Combinational requester selection: fixed priority (scan from 0) or round-robin
// (scan from rr_ptr, wrapping). Produces one-hot and binary grant.
module rv32_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_WIDTH = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_WIDTH-1:0] rr_ptr,
    input  logic                 round_robin,
    output logic [NUM_PORTS-1:0] grant_onehot,
    output logic [PTR_WIDTH-1:0] grant_bin
);

    always_comb begin
        int   start;
        int   idx;
        logic found;
        grant_onehot = '0;
        grant_bin    = '0;
        found        = 1'b0;
        idx          = 0;
        start        = round_robin ? int'(rr_ptr) : 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = start + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!found && req[idx]) begin
                found             = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_bin         = PTR_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/rv32_bus_arbiter.sv
// Shares one valid/ready memory bus between several rv32 requesters with an
// IDLE arbitration cycle, registered bus fields and an optional wait-state timeout.
module rv32_bus_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ROUND_ROBIN    = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              port_valid_in,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   port_address_in,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] port_write_mask_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   port_write_value_in,
    output logic [NUM_PORTS-1:0]              port_ready_out,
    output logic [NUM_PORTS-1:0]              port_error_out,
    output logic [DATA_WIDTH-1:0]             port_read_value_out,
    output logic                              bus_valid_out,
    output logic [ADDR_WIDTH-1:0]             bus_address_out,
    output logic [DATA_WIDTH/8-1:0]           bus_write_mask_out,
    output logic [DATA_WIDTH-1:0]             bus_write_value_out,
    input  logic                              bus_ready_in,
    input  logic [DATA_WIDTH-1:0]             bus_read_value_in
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    bus_state_t    state_reg, state_next;
    logic [PTR_W-1:0] grant_reg, grant_next;
    logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    rv32_bus_req_t req_reg, req_next;
    rv32_bus_req_t port_req [NUM_PORTS];

    logic [NUM_PORTS-1:0] arb_onehot;
    logic [PTR_W-1:0]     arb_bin;
    logic                 busy;
    logic                 timeout_hit;
    logic                 xfer_done;
    logic                 req_unused;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_req[gi].address     = RV32_BUS_MAX_ADDR'(port_address_in[gi*ADDR_WIDTH +: ADDR_WIDTH]);
            assign port_req[gi].write_mask  = RV32_BUS_MAX_MASK'(port_write_mask_in[gi*MASK_WIDTH +: MASK_WIDTH]);
            assign port_req[gi].write_value = RV32_BUS_MAX_DATA'(port_write_value_in[gi*DATA_WIDTH +: DATA_WIDTH]);
            assign port_ready_out[gi] = xfer_done && (grant_reg == PTR_W'(gi));
            assign port_error_out[gi] = busy && timeout_hit && (grant_reg == PTR_W'(gi));
        end
    endgenerate

    rv32_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_WIDTH (PTR_W)
    ) u_arbiter (
        .req          (port_valid_in),
        .rr_ptr       (rr_ptr_reg),
        .round_robin  (ROUND_ROBIN != 0),
        .grant_onehot (arb_onehot),
        .grant_bin    (arb_bin)
    );

    assign busy        = (state_reg == BUSY);
    // A bus response in the limit cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt_reg == TIMEOUT_LAST) && !bus_ready_in;
    assign xfer_done   = busy && (bus_ready_in || timeout_hit);

    assign port_read_value_out = (busy && bus_ready_in) ? bus_read_value_in : '0;
    assign bus_valid_out       = busy;
    assign bus_address_out     = req_reg.address[ADDR_WIDTH-1:0];
    assign bus_write_mask_out  = req_reg.write_mask[MASK_WIDTH-1:0];
    assign bus_write_value_out = req_reg.write_value[DATA_WIDTH-1:0];
    assign req_unused          = ^req_reg;

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        rr_ptr_next   = rr_ptr_reg;
        wait_cnt_next = wait_cnt_reg;
        req_next      = req_reg;
        case (state_reg)
            IDLE: begin
                if (|arb_onehot) begin
                    state_next    = BUSY;
                    grant_next    = arb_bin;
                    wait_cnt_next = '0;
                    req_next      = port_req[arb_bin];
                end
            end
            BUSY: begin
                if (xfer_done) begin
                    state_next = IDLE;
                    if (ROUND_ROBIN != 0) begin
                        rr_ptr_next = (grant_reg == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_reg + 1'b1;
                    end
                end else if (TIMEOUT_CYCLES > 0) begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            rr_ptr_reg   <= '0;
            wait_cnt_reg <= '0;
            req_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            rr_ptr_reg   <= rr_ptr_next;
            wait_cnt_reg <= wait_cnt_next;
            req_reg      <= req_next;
        end
    end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Bench for rv32_bus_arbiter: directed scenarios on three configurations plus a
// randomized round-robin run checked against a transaction-level model.
module tb_rv32_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   checks = 0;
    int   errors = 0;

    // A: 2 ports, fixed priority, timeout 4
    logic [1:0]  a_valid;  logic [63:0] a_addr;  logic [7:0]  a_mask;  logic [63:0] a_wdata;
    logic [1:0]  a_ready;  logic [1:0]  a_error; logic [31:0] a_rdata;
    logic        a_bvalid; logic [31:0] a_baddr; logic [3:0]  a_bmask; logic [31:0] a_bwdata;
    logic        a_bready; logic [31:0] a_brdata;
    // B: 3 ports, round-robin, no timeout
    logic [2:0]  b_valid;  logic [95:0] b_addr;  logic [11:0] b_mask;  logic [95:0] b_wdata;
    logic [2:0]  b_ready;  logic [2:0]  b_error; logic [31:0] b_rdata;
    logic        b_bvalid; logic [31:0] b_baddr; logic [3:0]  b_bmask; logic [31:0] b_bwdata;
    logic        b_bready; logic [31:0] b_brdata;
    // C: 2 ports, fixed priority, timeout 2
    logic [1:0]  c_valid;  logic [63:0] c_addr;  logic [7:0]  c_mask;  logic [63:0] c_wdata;
    logic [1:0]  c_ready;  logic [1:0]  c_error; logic [31:0] c_rdata;
    logic        c_bvalid; logic [31:0] c_baddr; logic [3:0]  c_bmask; logic [31:0] c_bwdata;
    logic        c_bready; logic [31:0] c_brdata;

    rv32_bus_arbiter #(.NUM_PORTS(2), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .port_valid_in(a_valid), .port_address_in(a_addr),
        .port_write_mask_in(a_mask), .port_write_value_in(a_wdata), .port_ready_out(a_ready),
        .port_error_out(a_error), .port_read_value_out(a_rdata), .bus_valid_out(a_bvalid),
        .bus_address_out(a_baddr), .bus_write_mask_out(a_bmask), .bus_write_value_out(a_bwdata),
        .bus_ready_in(a_bready), .bus_read_value_in(a_brdata));

    rv32_bus_arbiter #(.NUM_PORTS(3), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .port_valid_in(b_valid), .port_address_in(b_addr),
        .port_write_mask_in(b_mask), .port_write_value_in(b_wdata), .port_ready_out(b_ready),
        .port_error_out(b_error), .port_read_value_out(b_rdata), .bus_valid_out(b_bvalid),
        .bus_address_out(b_baddr), .bus_write_mask_out(b_bmask), .bus_write_value_out(b_bwdata),
        .bus_ready_in(b_bready), .bus_read_value_in(b_brdata));

    rv32_bus_arbiter #(.NUM_PORTS(2), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(2)) dut_c (
        .clk(clk), .reset(reset), .port_valid_in(c_valid), .port_address_in(c_addr),
        .port_write_mask_in(c_mask), .port_write_value_in(c_wdata), .port_ready_out(c_ready),
        .port_error_out(c_error), .port_read_value_out(c_rdata), .bus_valid_out(c_bvalid),
        .bus_address_out(c_baddr), .bus_write_mask_out(c_bmask), .bus_write_value_out(c_bwdata),
        .bus_ready_in(c_bready), .bus_read_value_in(c_brdata));

    // Every task starts and ends 1 time unit after a rising edge (the drive point).
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_valid = 2'b11; a_addr = {32'h0000_0A00, 32'h0000_0B00}; a_mask = 8'hFF; a_wdata = '1;
        b_valid = 3'b111; b_addr = '1; c_valid = 2'b11; c_addr = '1;
        a_bready = 1'b1; b_bready = 1'b1; c_bready = 1'b1;
        repeat (2) next_cycle();
        @(negedge clk);
        checks++; if (a_bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid_a got %b want 0", a_bvalid); end
        checks++; if (a_baddr !== 32'h0) begin errors++; $display("FAIL reset_baddr got %h want 0", a_baddr); end
        checks++; if ({a_bmask, a_bwdata} !== 36'h0) begin errors++; $display("FAIL reset_bfields got %h/%h want 0", a_bmask, a_bwdata); end
        checks++; if ({a_ready, a_error} !== 4'b0) begin errors++; $display("FAIL reset_pulses_a got %b/%b want 0", a_ready, a_error); end
        checks++; if ({b_bvalid, b_ready, c_bvalid, c_ready} !== 7'b0) begin errors++; $display("FAIL reset_bc got %b %b %b %b want 0", b_bvalid, b_ready, c_bvalid, c_ready); end
        next_cycle();
        reset = 1'b0;
        a_valid = '0; b_valid = '0; c_valid = '0; a_bready = 1'b0; b_bready = 1'b0; c_bready = 1'b0;
        next_cycle();
    endtask

    task automatic test_fixed_priority();
        a_valid = 2'b11; a_addr = {32'h0000_0200, 32'h0000_0100};
        a_mask = {4'hF, 4'h0}; a_wdata = {32'hDEADBEEF, 32'h0};
        a_bready = 1'b1; a_brdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++; if (a_bvalid !== 1'b0) begin errors++; $display("FAIL fp_c0_bvalid got %b want 0", a_bvalid); end
        next_cycle(); @(negedge clk);
        checks++; if ({a_bvalid, a_baddr, a_bmask} !== {1'b1, 32'h100, 4'h0}) begin errors++; $display("FAIL fp_c1_bus got %b %h %h want 1 100 0", a_bvalid, a_baddr, a_bmask); end
        checks++; if (a_ready !== 2'b01) begin errors++; $display("FAIL fp_c1_ready got %b want 01", a_ready); end
        checks++; if (a_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL fp_c1_rdata got %h want cafef00d", a_rdata); end
        next_cycle(); a_valid = 2'b10; @(negedge clk);
        checks++; if ({a_bvalid, a_ready} !== 3'b0) begin errors++; $display("FAIL fp_c2_idle got %b %b want 0 00", a_bvalid, a_ready); end
        next_cycle(); @(negedge clk);
        checks++; if ({a_bvalid, a_baddr, a_bmask, a_bwdata} !== {1'b1, 32'h200, 4'hF, 32'hDEADBEEF}) begin errors++; $display("FAIL fp_c3_bus got %b %h %h %h want 1 200 f deadbeef", a_bvalid, a_baddr, a_bmask, a_bwdata); end
        checks++; if ({a_ready, a_error} !== 4'b1000) begin errors++; $display("FAIL fp_c3_ready got %b/%b want 10/00", a_ready, a_error); end
        next_cycle(); a_valid = '0; a_bready = 1'b0;
        next_cycle();
    endtask

    task automatic test_wait_states();
        a_valid = 2'b10; a_addr = {32'h0000_3000, 32'h0}; a_mask = 8'h00; a_bready = 1'b0;
        @(negedge clk);
        for (int w = 1; w <= 3; w++) begin
            next_cycle();
            if (w == 1) a_addr[63:32] = $urandom;
            @(negedge clk);
            checks++; if ({a_bvalid, a_baddr, a_ready} !== {1'b1, 32'h3000, 2'b00}) begin errors++; $display("FAIL ws_hold_%0d got %b %h %b want 1 3000 00", w, a_bvalid, a_baddr, a_ready); end
        end
        next_cycle(); a_bready = 1'b1; a_brdata = 32'h1234_5678; @(negedge clk);
        checks++; if ({a_ready, a_error} !== 4'b1000) begin errors++; $display("FAIL ws_ready got %b/%b want 10/00", a_ready, a_error); end
        checks++; if (a_rdata !== 32'h1234_5678) begin errors++; $display("FAIL ws_rdata got %h want 12345678", a_rdata); end
        next_cycle(); a_valid = '0; a_bready = 1'b0; @(negedge clk);
        checks++; if ({a_bvalid, a_ready} !== 3'b0) begin errors++; $display("FAIL ws_after got %b %b want 0 00", a_bvalid, a_ready); end
        next_cycle();
    endtask

    task automatic test_timeout();
        a_valid = 2'b01; a_addr = {32'h0, 32'h0000_0400}; a_mask = 8'h03; a_wdata = {32'h0, 32'h55};
        a_bready = 1'b0; a_brdata = 32'hFFFF_FFFF;
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            next_cycle(); @(negedge clk);
            checks++; if ({a_bvalid, a_ready, a_error} !== 5'b10000) begin errors++; $display("FAIL to_wait_%0d got %b %b %b want 1 00 00", c, a_bvalid, a_ready, a_error); end
        end
        next_cycle(); @(negedge clk);
        checks++; if ({a_ready, a_error} !== 4'b0101) begin errors++; $display("FAIL to_pulse got %b/%b want 01/01", a_ready, a_error); end
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata got %h want 0", a_rdata); end
        next_cycle(); a_valid = '0; @(negedge clk);
        checks++; if ({a_bvalid, a_ready, a_error} !== 5'b0) begin errors++; $display("FAIL to_idle got %b %b %b want 0", a_bvalid, a_ready, a_error); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        a_valid = 2'b10; a_addr = {32'h0000_0500, 32'h0}; a_mask = 8'hF0; a_wdata = {32'h1122_3344, 32'h0};
        a_bready = 1'b0;
        next_cycle(); next_cycle();
        reset = 1'b1; @(negedge clk);
        checks++; if ({a_bvalid, a_ready, a_error} !== 5'b10000) begin errors++; $display("FAIL rm_wait2 got %b %b %b want 1 00 00", a_bvalid, a_ready, a_error); end
        next_cycle(); reset = 1'b0; a_valid = '0; a_bready = 1'b1; @(negedge clk);
        checks++; if ({a_bvalid, a_ready, a_error} !== 5'b0) begin errors++; $display("FAIL rm_after got %b %b %b want 0", a_bvalid, a_ready, a_error); end
        checks++; if (a_baddr !== 32'h0) begin errors++; $display("FAIL rm_baddr got %h want 0", a_baddr); end
        next_cycle(); a_bready = 1'b0;
        next_cycle();
    endtask

    task automatic test_timeout_edge();
        c_valid = 2'b01; c_addr = {32'h0, 32'h0000_0600}; c_mask = 8'h00; c_bready = 1'b0;
        @(negedge clk);
        next_cycle(); @(negedge clk);
        checks++; if ({c_bvalid, c_ready} !== 3'b100) begin errors++; $display("FAIL te_wait got %b %b want 1 00", c_bvalid, c_ready); end
        next_cycle(); c_bready = 1'b1; c_brdata = 32'hA5A5_0F0F; @(negedge clk);
        checks++; if ({c_ready, c_error} !== 4'b0100) begin errors++; $display("FAIL te_edge got %b/%b want 01/00", c_ready, c_error); end
        checks++; if (c_rdata !== 32'hA5A5_0F0F) begin errors++; $display("FAIL te_rdata got %h want a5a50f0f", c_rdata); end
        next_cycle(); c_valid = 2'b10; c_bready = 1'b0; @(negedge clk);
        checks++; if (c_bvalid !== 1'b0) begin errors++; $display("FAIL te_idle got %b want 0", c_bvalid); end
        next_cycle(); @(negedge clk);
        checks++; if ({c_ready, c_error} !== 4'b0) begin errors++; $display("FAIL te_wait2 got %b/%b want 00/00", c_ready, c_error); end
        next_cycle(); @(negedge clk);
        checks++; if ({c_ready, c_error, c_rdata} !== {4'b1010, 32'h0}) begin errors++; $display("FAIL te_timeout got %b/%b %h want 10/10 0", c_ready, c_error, c_rdata); end
        next_cycle(); c_valid = '0;
        next_cycle();
    endtask

    task automatic test_round_robin();
        int exp_port;
        b_valid = 3'b111; b_addr = {32'h3000, 32'h2000, 32'h1000}; b_mask = '0; b_bready = 1'b1;
        for (int t = 0; t < 7; t++) begin
            exp_port = t % 3;
            @(negedge clk);
            checks++; if (b_bvalid !== 1'b0) begin errors++; $display("FAIL rr_idle_%0d got %b want 0", t, b_bvalid); end
            next_cycle(); @(negedge clk);
            checks++; if ({b_baddr, b_ready} !== {32'(32'h1000 * (exp_port + 1)), 3'(1 << exp_port)}) begin errors++; $display("FAIL rr_grant_%0d got %h %b want port %0d", t, b_baddr, b_ready, exp_port); end
            next_cycle();
        end
        // Pointer now sits at port 1; reset must bring it back to port 0.
        reset = 1'b1;
        next_cycle(); reset = 1'b0; @(negedge clk);
        checks++; if (b_bvalid !== 1'b0) begin errors++; $display("FAIL rr_rst_idle got %b want 0", b_bvalid); end
        next_cycle(); @(negedge clk);
        checks++; if ({b_baddr, b_ready} !== {32'h1000, 3'b001}) begin errors++; $display("FAIL rr_rst_grant got %h %b want 1000 001", b_baddr, b_ready); end
        next_cycle(); b_valid = '0; b_bready = 1'b0;
        next_cycle();
    endtask

    task automatic test_random();
        logic [2:0]  p_valid;
        logic [31:0] p_addr  [3];
        logic [3:0]  p_mask  [3];
        logic [31:0] p_wdata [3];
        logic [2:0]  exp_ready;
        bit          m_busy;
        int          m_grant, m_ptr, done_port;
        reset = 1'b1; next_cycle(); reset = 1'b0;
        p_valid = '0; m_busy = 1'b0; m_grant = 0; m_ptr = 0; done_port = -1;
        for (int i = 0; i < 3; i++) begin p_addr[i] = '0; p_mask[i] = '0; p_wdata[i] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done_port >= 0) p_valid[done_port] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (!p_valid[i] && i != done_port && $urandom_range(0, 2) == 0) begin
                    p_valid[i] = 1'b1; p_addr[i] = $urandom; p_mask[i] = 4'($urandom); p_wdata[i] = $urandom;
                end
                b_addr[i*32 +: 32] = p_addr[i]; b_mask[i*4 +: 4] = p_mask[i]; b_wdata[i*32 +: 32] = p_wdata[i];
            end
            b_valid = p_valid; b_bready = ($urandom_range(0, 2) == 0); b_brdata = $urandom;
            @(negedge clk);
            exp_ready = (m_busy && b_bready) ? 3'(1 << m_grant) : 3'b000;
            checks++; if (b_bvalid !== m_busy) begin errors++; $display("FAIL rnd_bvalid cyc %0d got %b want %b", cyc, b_bvalid, m_busy); end
            checks++; if ({b_ready, b_error} !== {exp_ready, 3'b000}) begin errors++; $display("FAIL rnd_ready cyc %0d got %b/%b want %b/000", cyc, b_ready, b_error, exp_ready); end
            if (m_busy) begin
                checks++; if ({b_baddr, b_bmask, b_bwdata} !== {p_addr[m_grant], p_mask[m_grant], p_wdata[m_grant]}) begin errors++; $display("FAIL rnd_bus cyc %0d got %h %h %h want port %0d", cyc, b_baddr, b_bmask, b_bwdata, m_grant); end
            end
            if (m_busy && b_bready) begin
                checks++; if (b_rdata !== b_brdata) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h want %h", cyc, b_rdata, b_brdata); end
            end
            done_port = -1;
            if (m_busy) begin
                if (b_bready) begin
                    m_busy = 1'b0; done_port = m_grant; m_ptr = (m_grant + 1) % 3;
                end
            end else begin
                for (int k = 2; k >= 0; k--) begin
                    if (p_valid[(m_ptr + k) % 3]) begin m_busy = 1'b1; m_grant = (m_ptr + k) % 3; end
                end
            end
            next_cycle();
        end
        b_valid = '0; b_bready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_valid = '0; a_addr = '0; a_mask = '0; a_wdata = '0; a_bready = 1'b0; a_brdata = '0;
        b_valid = '0; b_addr = '0; b_mask = '0; b_wdata = '0; b_bready = 1'b0; b_brdata = '0;
        c_valid = '0; c_addr = '0; c_mask = '0; c_wdata = '0; c_bready = 1'b0; c_brdata = '0;
        #1;
        test_reset();
        test_fixed_priority();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_timeout_edge();
        test_round_robin();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
